alu_issue_scheduler: RTL and testbench
======================================

# alu_issue_scheduler

Selects ready reservation-station entries and dispatches their indices to a pool of ALUs. It sits between the ALU reservation station and the ALU/ACU units. It tracks which entries are in flight so that an entry is never issued twice before its completion broadcast. Round-robin selection across entries prevents starvation.

## Interface
- SIZE, 8, number of reservation-station entries; power of two, at least 2
- NUM_ALU, 2, number of execution units fed; range 1..SIZE
- IW, $clog2(SIZE), entry-index width (derived; do not override)

- clk  in  1  clock; all state updates on the rising edge
- rst  in  1  asynchronous, active-low reset
- flush  in  1  synchronous pipeline flush; dominates all other events
- rs_ready  in  SIZE  per-entry "operands resolved and valid" from the reservation station
- done  in  SIZE  per-entry completion pulse from the ALU broadcast bus
- alu_ready  in  NUM_ALU  execution unit k can accept an issue this cycle
- issue_valid  out  NUM_ALU  slot k holds an issue for unit k
- issue_idx  out  NUM_ALU*IW  packed entry index per slot; slot k is bits [k*IW +: IW]
- inflight  out  SIZE  entry has been picked and has not yet completed
- issued_count  out  32  statistics, see Configuration
- stall_count  out  32  statistics, see Configuration

## Operation
- Candidate set: cand = rs_ready & ~inflight & ~done.
- Free slot: a slot is free when issue_valid[k] = 0, or when issue_valid[k] & alu_ready[k] (it is accepted this cycle).
- Pick order:
  - Free slots are served in ascending k.
  - Each free slot takes the first cand bit at or after rr_ptr, searching cyclically mod SIZE.
  - An entry already taken by a lower-numbered slot in the same cycle is excluded.
  - A free slot with no candidate loads issue_valid = 0.
- On pick:
  - Slot loads issue_valid = 1 and issue_idx = entry.
  - inflight[entry] is set.
- Hold rule: while issue_valid[k] = 1 and alu_ready[k] = 0, issue_idx[k] is held stable and valid stays high. Only flush or reset may drop it.
- Completion: done[i] clears inflight[i] on the next edge. done for an entry whose index still sits unaccepted in a slot is a protocol violation; the bench asserts against it.
- Pointer update:
  - rr_ptr = (highest-priority-order last picked entry + 1) mod SIZE, i.e. one past the final pick in cyclic order.
  - rr_ptr is unchanged if nothing is picked.
- Flush: on the next edge, issue_valid = 0, inflight = 0 and rr_ptr = 0. No pick or done is applied in that cycle.

## Timing
- Reset values: issue_valid = 0, issue_idx = 0, inflight = 0, rr_ptr = 0, issued_count = 0, stall_count = 0.
- Reset takes effect asynchronously on the falling edge of rst. Reset asserted mid-handshake discards the slot contents.
- All outputs are registered; there is no combinational path from any input to any output.
- Issue latency: rs_ready[i] rising in cycle t gives issue_valid with issue_idx = i at t+1, provided a slot is free in cycle t.
- Back-to-back issue: an accepted slot reloads in the same edge, giving one issue per unit per cycle at full throughput.
- Same-cycle events on one entry:
  - done[i] and rs_ready[i] together: i is not a candidate, and inflight[i] clears.
  - An entry completing in cycle t may be reissued no earlier than t+1, and only if rs_ready[i] is still high. The RS clears valid on done, so normally it is not.
- Wrap-around: rr_ptr = SIZE-1 with a candidate at entry 0 picks 0 and sets rr_ptr = 1.
- Full: when all SIZE entries are inflight, no slot loads. Slots drain as units accept.

## Configuration
- ISSUE_STATS_EN:
  - Defined: issued_count increments by the number of slots accepted (valid & alu_ready) each cycle. stall_count increments by 1 in each cycle where cand != 0 and no slot is free. Both wrap mod 2^32 and clear on reset and on flush.
  - Undefined: both ports are driven constant 0 and the counters are not synthesized.

## Test plan
- Single entry: reset, then rs_ready = 8'h04 at t0 with alu_ready = 2'b11 → at t0+1 issue_valid = 2'b01, issue_idx[0] = 2, inflight = 8'h04. Pulse done[2] → inflight = 0 next cycle.
- Two units, round-robin: rs_ready = 8'hFF held, alu_ready = 2'b11, done returned 1 cycle after accept → issue order {0,1},{2,3},{4,5},{6,7},{0,1}. Each entry is issued exactly once per completion.
- Backpressure: rs_ready = 8'h30, alu_ready = 2'b00 for 5 cycles → issue_valid = 2'b11 with idx {4,5} stable for all 5 cycles. With ISSUE_STATS_EN, stall_count stays 0 because there is no candidate. Raising alu_ready[0] → slot 0 is accepted and issued_count = 1.
- Wrap and starvation: force rr_ptr to 7 by prior picks, rs_ready = 8'h81 → entry 7 goes to slot 0, entry 0 to slot 1, and rr_ptr = 1.
- Flush mid-operation: 3 entries inflight and slot 1 unaccepted, assert flush with done[x] the same cycle → next cycle issue_valid = 0, inflight = 0, counters = 0. rs_ready = 8'h01 then issues entry 0 one cycle later.
- Async reset: drop rst between clock edges while issue_valid = 2'b11 → outputs are zero immediately, before the next edge, and stay zero until rst rises and one edge elapses.

Source files
------------

// File: rtl/alu_issue_scheduler.sv
// Round-robin issue scheduler: picks ready reservation-station entries into per-ALU issue slots.
// Define ISSUE_STATS_EN to build the issued/stall statistics counters; otherwise they read 0.
module alu_issue_scheduler #(
    parameter  int SIZE    = 8,
    parameter  int NUM_ALU = 2,
    localparam int IW      = $clog2(SIZE)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush,
    input  logic [SIZE-1:0]       rs_ready,
    input  logic [SIZE-1:0]       done,
    input  logic [NUM_ALU-1:0]    alu_ready,
    output logic [NUM_ALU-1:0]    issue_valid,
    output logic [NUM_ALU*IW-1:0] issue_idx,
    output logic [SIZE-1:0]       inflight,
    output logic [31:0]           issued_count,
    output logic [31:0]           stall_count
);

    logic [NUM_ALU-1:0]    valid_q, valid_d;
    logic [NUM_ALU*IW-1:0] idx_q, idx_d;
    logic [SIZE-1:0]       inflight_q, inflight_d;
    logic [IW-1:0]         rr_ptr_q, rr_ptr_d;
    logic [SIZE-1:0]       cand, avail, picked;
    logic [NUM_ALU-1:0]    slot_free;
    logic [IW-1:0]         scan, sel;
    logic                  found;

    // An entry completing this cycle is never a candidate, even if still marked ready.
    assign cand = rs_ready & ~inflight_q & ~done;

    always_comb begin
        valid_d   = valid_q;
        idx_d     = idx_q;
        rr_ptr_d  = rr_ptr_q;
        avail     = cand;
        picked    = '0;
        slot_free = '0;
        scan      = '0;
        sel       = '0;
        found     = 1'b0;
        for (int k = 0; k < NUM_ALU; k++) begin
            slot_free[k] = !valid_q[k] || alu_ready[k];
            if (slot_free[k]) begin
                found = 1'b0;
                sel   = '0;
                for (int j = 0; j < SIZE; j++) begin
                    scan = rr_ptr_q + IW'(j);
                    if (!found && avail[scan]) begin
                        found = 1'b1;
                        sel   = scan;
                    end
                end
                valid_d[k] = found;
                if (found) begin
                    idx_d[k*IW +: IW] = sel;
                    avail[sel]        = 1'b0;
                    picked[sel]       = 1'b1;
                    rr_ptr_d          = sel + IW'(1);
                end
            end
        end
        inflight_d = (inflight_q & ~done) | picked;
        if (flush) begin
            valid_d    = '0;
            inflight_d = '0;
            rr_ptr_d   = '0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid_q    <= '0;
            idx_q      <= '0;
            inflight_q <= '0;
            rr_ptr_q   <= '0;
        end else begin
            valid_q    <= valid_d;
            idx_q      <= idx_d;
            inflight_q <= inflight_d;
            rr_ptr_q   <= rr_ptr_d;
        end
    end

    assign issue_valid = valid_q;
    assign issue_idx   = idx_q;
    assign inflight    = inflight_q;

`ifdef ISSUE_STATS_EN
    logic [31:0] issued_q, issued_d, stall_q, stall_d, accepted;

    always_comb begin
        accepted = '0;
        for (int k = 0; k < NUM_ALU; k++) begin
            accepted = accepted + 32'(valid_q[k] & alu_ready[k]);
        end
        issued_d = issued_q + accepted;
        stall_d  = stall_q + 32'((|cand) && !(|slot_free));
        if (flush) begin
            issued_d = '0;
            stall_d  = '0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            issued_q <= '0;
            stall_q  <= '0;
        end else begin
            issued_q <= issued_d;
            stall_q  <= stall_d;
        end
    end

    assign issued_count = issued_q;
    assign stall_count  = stall_q;
`else
    assign issued_count = '0;
    assign stall_count  = '0;
`endif

endmodule

// File: tb/tb_alu_issue_scheduler.sv
// Self-checking bench for alu_issue_scheduler: scenario tasks with an issue scoreboard queue.
module tb_alu_issue_scheduler;
    localparam int SIZE    = 8;
    localparam int NUM_ALU = 2;
    localparam int IW      = 3;
`ifdef ISSUE_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic                  clk = 1'b0;
    logic                  rst = 1'b0;
    logic                  flush = 1'b0;
    logic [SIZE-1:0]       rs_ready = '0;
    logic [SIZE-1:0]       done = '0;
    logic [NUM_ALU-1:0]    alu_ready = '0;
    logic [NUM_ALU-1:0]    issue_valid;
    logic [NUM_ALU*IW-1:0] issue_idx;
    logic [SIZE-1:0]       inflight;
    logic [31:0]           issued_count;
    logic [31:0]           stall_count;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [1:0] valid;
        logic [2:0] i0;
        logic [2:0] i1;
    } exp_t;
    exp_t sb[$];

    alu_issue_scheduler #(.SIZE(SIZE), .NUM_ALU(NUM_ALU)) dut (
        .clk(clk), .rst(rst), .flush(flush), .rs_ready(rs_ready), .done(done),
        .alu_ready(alu_ready), .issue_valid(issue_valid), .issue_idx(issue_idx),
        .inflight(inflight), .issued_count(issued_count), .stall_count(stall_count)
    );

    always #5 clk = ~clk;

    // Completion for an entry still waiting unaccepted in a slot is illegal stimulus.
    always @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < NUM_ALU; k++) begin
                assert (!(issue_valid[k] && !alu_ready[k] && done[issue_idx[k*IW +: IW]]))
                else begin
                    errors++;
                    $display("FAIL protocol done on unaccepted slot %0d idx %0d", k, issue_idx[k*IW +: IW]);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [1:0] v, input logic [2:0] i0, input logic [2:0] i1);
        exp_t e;
        e.valid = v;
        e.i0    = i0;
        e.i1    = i1;
        sb.push_back(e);
    endtask

    task automatic sb_pop(input string name);
        exp_t e;
        checks++;
        if (sb.size() == 0) begin
            errors++;
            $display("FAIL %s scoreboard empty, got valid=%b", name, issue_valid);
        end else begin
            e = sb.pop_front();
            if (issue_valid !== e.valid ||
                (e.valid[0] && issue_idx[2:0] !== e.i0) ||
                (e.valid[1] && issue_idx[5:3] !== e.i1)) begin
                errors++;
                $display("FAIL %s got valid=%b idx0=%0d idx1=%0d, required valid=%b idx0=%0d idx1=%0d",
                         name, issue_valid, issue_idx[2:0], issue_idx[5:3], e.valid, e.i0, e.i1);
            end
        end
    endtask

    task automatic do_reset();
        rst = 1'b0; flush = 1'b0; rs_ready = '0; done = '0; alu_ready = '0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        tick();
    endtask

    task automatic test_reset();
        rst = 1'b0; flush = 1'b0; rs_ready = 8'hFF; done = '0; alu_ready = '1;
        @(posedge clk);
        #1;
        checks++;
        if (issue_valid !== 2'b00 || issue_idx !== 6'd0 || inflight !== 8'h00 ||
            issued_count !== 32'd0 || stall_count !== 32'd0) begin
            errors++;
            $display("FAIL reset_state valid=%b idx=%h inflight=%h issued=%0d stall=%0d, required all 0",
                     issue_valid, issue_idx, inflight, issued_count, stall_count);
        end
        do_reset();
    endtask

    task automatic test_single();
        do_reset();
        rs_ready = 8'h04; alu_ready = 2'b11;
        push(2'b01, 3'd2, 3'd0);
        tick();
        sb_pop("single_issue");
        checks++;
        if (inflight !== 8'h04) begin
            errors++; $display("FAIL single_inflight got %h required 04", inflight);
        end
        rs_ready = 8'h00; done = 8'h04;
        push(2'b00, 3'd0, 3'd0);
        tick();
        sb_pop("single_drain");
        done = '0;
        checks++;
        if (inflight !== 8'h00) begin
            errors++; $display("FAIL single_done got %h required 00", inflight);
        end
        checks++;
        if (issued_count !== (STATS ? 32'd1 : 32'd0)) begin
            errors++; $display("FAIL single_issued got %0d required %0d", issued_count, STATS ? 1 : 0);
        end
    endtask

    task automatic test_round_robin();
        do_reset();
        rs_ready = 8'hFF; alu_ready = 2'b11;
        for (int e = 1; e <= 5; e++) begin
            done = (e >= 3) ? (8'h03 << (2 * ((e - 3) % 4))) : 8'h00;
            push(2'b11, 3'((2 * (e - 1)) % 8), 3'((2 * (e - 1) + 1) % 8));
            tick();
            sb_pop("rr_issue");
        end
        done = '0; rs_ready = '0;
        checks++;
        if (inflight !== 8'hC3) begin
            errors++; $display("FAIL rr_inflight got %h required c3", inflight);
        end
        checks++;
        if (issued_count !== (STATS ? 32'd8 : 32'd0)) begin
            errors++; $display("FAIL rr_issued got %0d required %0d", issued_count, STATS ? 8 : 0);
        end
    endtask

    task automatic test_backpressure();
        do_reset();
        rs_ready = 8'h30; alu_ready = 2'b00;
        for (int c = 0; c < 5; c++) begin
            push(2'b11, 3'd4, 3'd5);
            tick();
            sb_pop("bp_hold");
            checks++;
            if (stall_count !== 32'd0) begin
                errors++; $display("FAIL bp_no_stall got %0d required 0", stall_count);
            end
        end
        rs_ready = 8'h31;
        for (int c = 0; c < 2; c++) begin
            push(2'b11, 3'd4, 3'd5);
            tick();
            sb_pop("bp_stall_hold");
        end
        checks++;
        if (stall_count !== (STATS ? 32'd2 : 32'd0)) begin
            errors++; $display("FAIL bp_stall got %0d required %0d", stall_count, STATS ? 2 : 0);
        end
        alu_ready = 2'b01;
        push(2'b11, 3'd0, 3'd5);
        tick();
        sb_pop("bp_accept");
        checks++;
        if (issued_count !== (STATS ? 32'd1 : 32'd0) || stall_count !== (STATS ? 32'd2 : 32'd0)) begin
            errors++;
            $display("FAIL bp_counts got issued=%0d stall=%0d required issued=%0d stall=%0d",
                     issued_count, stall_count, STATS ? 1 : 0, STATS ? 2 : 0);
        end
    endtask

    task automatic test_wrap();
        do_reset();
        rs_ready = 8'h40; alu_ready = 2'b11;
        push(2'b01, 3'd6, 3'd0);
        tick();
        sb_pop("wrap_prime");
        rs_ready = 8'h81; done = 8'h40;
        push(2'b11, 3'd7, 3'd0);
        tick();
        sb_pop("wrap_pick");
        checks++;
        if (inflight !== 8'h81) begin
            errors++; $display("FAIL wrap_inflight got %h required 81", inflight);
        end
        rs_ready = 8'h00; done = 8'h81;
        push(2'b00, 3'd0, 3'd0);
        tick();
        sb_pop("wrap_drain");
        rs_ready = 8'h03; done = 8'h00;
        push(2'b11, 3'd1, 3'd0);
        tick();
        sb_pop("wrap_ptr_one");
        rs_ready = '0;
    endtask

    task automatic test_flush();
        do_reset();
        rs_ready = 8'h07; alu_ready = 2'b11;
        push(2'b11, 3'd0, 3'd1);
        tick();
        sb_pop("flush_pre1");
        alu_ready = 2'b01;
        push(2'b11, 3'd2, 3'd1);
        tick();
        sb_pop("flush_pre2");
        checks++;
        if (inflight !== 8'h07 || issued_count !== (STATS ? 32'd1 : 32'd0)) begin
            errors++;
            $display("FAIL flush_pre_state got inflight=%h issued=%0d required 07/%0d",
                     inflight, issued_count, STATS ? 1 : 0);
        end
        flush = 1'b1; done = 8'h01;
        push(2'b00, 3'd0, 3'd0);
        tick();
        sb_pop("flush_valid");
        checks++;
        if (inflight !== 8'h00 || issued_count !== 32'd0 || stall_count !== 32'd0) begin
            errors++;
            $display("FAIL flush_state got inflight=%h issued=%0d stall=%0d required 00/0/0",
                     inflight, issued_count, stall_count);
        end
        flush = 1'b0; done = '0; rs_ready = 8'h01; alu_ready = 2'b11;
        push(2'b01, 3'd0, 3'd0);
        tick();
        sb_pop("flush_reissue");
        rs_ready = '0;
    endtask

    task automatic test_async_reset();
        do_reset();
        rs_ready = 8'h03; alu_ready = 2'b00;
        push(2'b11, 3'd0, 3'd1);
        tick();
        sb_pop("areset_fill");
        #3;
        rst = 1'b0;
        #1;
        checks++;
        if (issue_valid !== 2'b00 || issue_idx !== 6'd0 || inflight !== 8'h00) begin
            errors++;
            $display("FAIL areset_immediate got valid=%b idx=%h inflight=%h required 0",
                     issue_valid, issue_idx, inflight);
        end
        tick();
        #3;
        rst = 1'b1;
        #1;
        checks++;
        if (issue_valid !== 2'b00 || inflight !== 8'h00) begin
            errors++;
            $display("FAIL areset_held got valid=%b inflight=%h required 0", issue_valid, inflight);
        end
        push(2'b11, 3'd0, 3'd1);
        tick();
        sb_pop("areset_resume");
        rs_ready = '0;
    endtask

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_backpressure();
        test_wrap();
        test_flush();
        test_async_reset();
        checks++;
        if (sb.size() != 0) begin
            errors++; $display("FAIL scoreboard_leftover got %0d entries required 0", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
